// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals of the UART TX arbiter.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [8*N-1:0] byte_in;
    logic [N-1:0]   ack;
    logic           tx_enable;
    logic [7:0]     tx_byte;
    logic           tx_busy;
    logic [GW-1:0]  grant;
    logic           active;
    logic           err;

    modport master (
        input  req, byte_in, tx_busy,
        output ack, tx_enable, tx_byte, grant, active, err
    );

    modport slave (
        output req, byte_in, tx_busy,
        input  ack, tx_enable, tx_byte, grant, active, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter between N
// byte sources. Each byte is launched once (ack + tx_enable pulse), then the
// arbiter waits for the transmitter's busy to rise and fall before granting again.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- abandon a launch whose busy
// never rises within TIMEOUT cycles and raise the sticky err flag.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] ptr_next;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [N-1:0]  ack_q, ack_d;
    logic          tx_en_q, tx_en_d;
    logic          found;
    int            win;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Pointer moves one past the winner held in grant_q once its byte is done.
    assign ptr_next = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;

    // Pick the first pending requester at or after ptr, scanning upward with wrap.
    always_comb begin
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                win   = (int'(ptr_q) + k) % N;
            end
        end
    end

    // Next-state and registered-output logic; ack/tx_enable are single-cycle pulses.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        tx_byte_d = tx_byte_q;
        ack_d     = '0;
        tx_en_d   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                // A transmitter still busy (e.g. across a reset) blocks launches.
                if (found && !bus.tx_busy) begin
                    grant_d    = win[GW-1:0];
                    tx_byte_d  = bus.byte_in[8*win +: 8];
                    ack_d[win] = 1'b1;
                    tx_en_d    = 1'b1;
                    state_d    = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Byte counts as consumed; skip past its owner and flag it.
                    err_d   = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    ptr_d   = ptr_next;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            tx_byte_q <= '0;
            ack_q     <= '0;
            tx_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            tx_byte_q <= tx_byte_d;
            ack_q     <= ack_d;
            tx_en_q   <= tx_en_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Launch-timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign bus.err        = 1'b0;
`endif

    assign bus.ack       = ack_q;
    assign bus.tx_enable = tx_en_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.grant     = grant_q;
    assign bus.active    = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random stimulus for uart_tx_arbiter, checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N)) bus();
    uart_tx_arbiter #(.N(N), .TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // reference model: transfer in flight, busy seen, pointer, last winner
    bit             m_inflight, m_seen;
    int             m_ptr, m_w, m_grant;
    logic [7:0]     m_byte;
    int             launches[$];
    // inputs that the most recent rising edge sampled
    logic [N-1:0]   p_req;
    logic [8*N-1:0] p_bytes;
    logic           p_busy;
    // stimulus behaviour
    int             req_mode;      // 0 hold, 1 drop on ack, 2 random
    bit             force_busy_en;
    logic           force_busy_val;
    int             fix_len;       // transmitter busy length, 0 = random
    int             tx_wait, tx_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic latch_inputs();
        p_req   = bus.req;
        p_bytes = bus.byte_in;
        p_busy  = bus.tx_busy;
    endtask

    task automatic model_reset();
        m_inflight = 0; m_seen = 0; m_ptr = 0; m_w = 0; m_grant = 0; m_byte = 8'h00;
    endtask

    // one clock: predict, compare all outputs, then drive the next inputs
    task automatic step();
        logic [N-1:0] e_ack;
        logic         e_en;
        int           w;
        @(negedge clk);
        e_ack = '0;
        e_en  = 1'b0;
        if (!m_inflight && (|p_req) && !p_busy) begin
            w          = pick(p_req, m_ptr);
            e_ack[w]   = 1'b1;
            e_en       = 1'b1;
            m_byte     = p_bytes[8*w +: 8];
            m_grant    = w;
            m_w        = w;
            m_inflight = 1;
            m_seen     = 0;
            launches.push_back(w);
        end else if (m_inflight) begin
            if (!m_seen) m_seen = p_busy;
            else if (!p_busy) begin
                m_inflight = 0;
                m_ptr      = (m_w + 1) % N;
            end
        end
        chk("ack", bus.ack, e_ack);
        chk("ack_onehot", ($countones(bus.ack) <= 1), 1);
        chk("tx_enable", bus.tx_enable, e_en);
        chk("tx_byte", bus.tx_byte, m_byte);
        chk("grant", bus.grant, m_grant);
        chk("active", bus.active, m_inflight);
        chk("err", bus.err, 0);

        case (req_mode)
            1: if (e_en) bus.req[m_w] = 1'b0;
            2: for (int i = 0; i < N; i++) begin
                if (e_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
                    else bus.byte_in[8*i +: 8] = 8'($urandom);
                end else if (bus.req[i]) begin
                    if ($urandom_range(0, 15) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.byte_in[8*i +: 8] = 8'($urandom);
                end
            end
            default: ;
        endcase

        if (e_en) begin
            tx_wait = $urandom_range(0, 2);
            tx_left = (fix_len > 0) ? fix_len : $urandom_range(1, 6);
        end
        if (force_busy_en) bus.tx_busy = force_busy_val;
        else if (tx_wait > 0) begin bus.tx_busy = 1'b0; tx_wait--; end
        else if (tx_left > 0) begin bus.tx_busy = 1'b1; tx_left--; end
        else bus.tx_busy = 1'b0;
        latch_inputs();
    endtask

    task automatic run_until_launches(input string tag, input int n, input int budget);
        int c = 0;
        while (launches.size() < n && c < budget) begin step(); c++; end
        chk(tag, launches.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c = 0;
        while ((m_inflight || tx_left > 0 || tx_wait > 0 || bus.tx_busy) && c < budget) begin
            step(); c++;
        end
        chk(tag, m_inflight, 0);
    endtask

    task automatic set_req(input logic [N-1:0] r);
        bus.req = r;
        latch_inputs();
    endtask

    task automatic chk_order(input string tag, input int exp[$]);
        chk({tag, "_count"}, launches.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(tag, (launches.size() > i) ? launches[i] : -1, exp[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, bus.ack, 0);
        chk({tag, "_en"}, bus.tx_enable, 0);
        chk({tag, "_byte"}, bus.tx_byte, 0);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_active"}, bus.active, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        reset = 1'b0;
        bus.req = '0; bus.byte_in = '0; bus.tx_busy = 1'b0;
        req_mode = 0; force_busy_en = 0; force_busy_val = 1'b0;
        fix_len = 0; tx_wait = 0; tx_left = 0;
        model_reset();
        latch_inputs();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        // single request, 40-cycle transmitter
        req_mode = 1; fix_len = 40;
        bus.byte_in[7:0] = 8'hA5;
        set_req(4'b0001);
        run_until_launches("single_launch", 1, 10);
        wait_idle("single_idle", 100);
        chk_order("single_order", '{0});

        // two requesters held continuously
        launches.delete();
        req_mode = 0; fix_len = 3;
        bus.byte_in[15:8] = 8'h11; bus.byte_in[31:24] = 8'h33;
        set_req(4'b1010);
        run_until_launches("pair_launch", 4, 200);
        set_req(4'b0000);
        wait_idle("pair_idle", 50);
        chk_order("pair_order", '{1, 3, 1, 3});

        // all requesters held for eight transfers
        launches.delete();
        bus.byte_in = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        set_req(4'b1111);
        run_until_launches("all_launch", 8, 400);
        set_req(4'b0000);
        wait_idle("all_idle", 50);
        chk_order("all_order", '{0, 1, 2, 3, 0, 1, 2, 3});

        // transmitter busy while idle blocks the grant
        launches.delete();
        req_mode = 1;
        force_busy_en = 1; force_busy_val = 1'b1; bus.tx_busy = 1'b1;
        set_req(4'b0100);
        repeat (6) step();
        chk("busy_block", launches.size(), 0);
        force_busy_en = 0; bus.tx_busy = 1'b0;
        latch_inputs();
        step();
        chk("busy_release", launches.size(), 1);
        wait_idle("busy_idle", 50);
        chk_order("busy_order", '{2});

        // reset while the transmitter is mid-byte; pointer must return to 0
        launches.delete();
        fix_len = 20;
        set_req(4'b1000);
        for (int c = 0; c < 30 && !(m_inflight && m_seen); c++) step();
        chk("rst_reached_done", m_seen, 1);
        #1 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        reset = 1'b1;
        model_reset();
        launches.delete();
        set_req(4'b1010);
        run_until_launches("rst_launch", 1, 60);
        chk_order("rst_order", '{1});
        set_req(4'b0000);
        wait_idle("rst_idle", 80);

        // random requesters and transmitter timing
        launches.delete();
        req_mode = 2; fix_len = 0;
        repeat (2000) step();
        chk("random_progress", (launches.size() > 50), 1);
        req_mode = 0;
        set_req(4'b0000);
        wait_idle("random_idle", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
